// File: rtl/spi_mitm_sequencer.sv
// rtl/spi_mitm_sequencer.sv - per-frame SPI MITM controller: MOSI trigger match and MISO byte substitution
module spi_mitm_sequencer #(
  parameter int DATA_SIZE   = 8,
  parameter int CNT_W       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 ss_in,
  input  logic                 sclk_in,
  input  logic                 mosi_in,
  input  logic [DATA_SIZE-1:0] cfg_trigger,
  input  logic [DATA_SIZE-1:0] cfg_replace,
  input  logic [CNT_W-1:0]     cfg_count,
  input  logic                 cfg_arm,
  output logic                 armed,
  output logic                 frame_active,
  output logic                 miso_sel,
  output logic                 miso_repl_bit,
  output logic [DATA_SIZE-1:0] mosi_byte,
  output logic                 byte_done,
  output logic                 hit
);

  localparam int BCW = $clog2(DATA_SIZE + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_SIZE - 1);

  typedef enum logic [1:0] {IDLE, WAIT_TRIG, REPLACE, PASS} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] ss_sync, sclk_sync, mosi_sync;
  logic                   ss_d, sclk_d;
  logic                   ss_s, sclk_s, mosi_s;
  logic                   ss_rise, ss_fall, sclk_rise, sclk_fall;
  logic [BCW-1:0]         bit_cnt;
  logic [DATA_SIZE-1:0]   shift_in;
  logic [DATA_SIZE-1:0]   out_sr;
  logic [CNT_W-1:0]       rem;
  logic [DATA_SIZE-1:0]   new_byte;
  logic                   byte_end;
  logic                   trig_hit;

  // Synchronizers; ss chain resets high so a mid-frame reset release is not seen as a frame start
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      ss_sync   <= '1;
      sclk_sync <= '0;
      mosi_sync <= '0;
    end else begin
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_in};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_in};
    end
  end

  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // Edge-detect delay flops; previous-SS starts high so ss must be seen low before a frame can start
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      ss_d   <= 1'b1;
      sclk_d <= 1'b0;
    end else begin
      ss_d   <= ss_s;
      sclk_d <= sclk_s;
    end
  end

  assign ss_rise   = ss_s & ~ss_d;
  assign ss_fall   = ~ss_s & ss_d;
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;

  // Byte being completed by this rising edge, and whether it fires the trigger
  always_comb begin
    new_byte = {shift_in[DATA_SIZE-2:0], mosi_s};
    byte_end = (state != IDLE) && !ss_fall && sclk_rise && (bit_cnt == LAST_BIT);
    trig_hit = byte_end && (state == WAIT_TRIG) && (new_byte == cfg_trigger);
  end

  // Frame sequencer: capture, trigger compare, replacement shift-out and one-shot arming
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      armed         <= 1'b0;
      frame_active  <= 1'b0;
      miso_sel      <= 1'b0;
      miso_repl_bit <= 1'b0;
      mosi_byte     <= '0;
      byte_done     <= 1'b0;
      hit           <= 1'b0;
      bit_cnt       <= '0;
      shift_in      <= '0;
      out_sr        <= '0;
      rem           <= '0;
    end else begin
      byte_done <= 1'b0;
      hit       <= 1'b0;

      // A new arm request wins over the hit that consumes the current one
      if (cfg_arm) begin
        armed <= 1'b1;
      end else if (trig_hit) begin
        armed <= 1'b0;
      end

      if (ss_fall) begin
        // Frame end cancels any partial byte and any pending replacement
        state         <= IDLE;
        frame_active  <= 1'b0;
        miso_sel      <= 1'b0;
        miso_repl_bit <= 1'b0;
        bit_cnt       <= '0;
        shift_in      <= '0;
        rem           <= '0;
      end else if (state == IDLE) begin
        if (ss_rise) begin
          frame_active <= 1'b1;
          bit_cnt      <= '0;
          shift_in     <= '0;
          state        <= armed ? WAIT_TRIG : PASS;
        end
      end else begin
        if (sclk_rise) begin
          shift_in <= new_byte;
          if (byte_end) begin
            mosi_byte <= new_byte;
            byte_done <= 1'b1;
            bit_cnt   <= '0;
            if (trig_hit) begin
              hit <= 1'b1;
              if (cfg_count != '0) begin
                rem   <= cfg_count;
                state <= REPLACE;
              end else begin
                state <= PASS;
              end
            end else if (state == REPLACE) begin
              rem <= rem - CNT_W'(1);
              if (rem == CNT_W'(1)) begin
                state <= PASS;
              end
            end
          end else begin
            bit_cnt <= bit_cnt + BCW'(1);
          end
        end

        if (sclk_fall) begin
          if (state == REPLACE) begin
            if (bit_cnt == '0) begin
              out_sr        <= cfg_replace;
              miso_sel      <= 1'b1;
              miso_repl_bit <= cfg_replace[DATA_SIZE-1];
            end else begin
              out_sr        <= out_sr << 1;
              miso_repl_bit <= out_sr[DATA_SIZE-2];
            end
          end else begin
            // Dropping on the fall keeps the final replaced bit valid across its rising edge
            miso_sel      <= 1'b0;
            miso_repl_bit <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_mitm_sequencer.sv
// tb/tb_spi_mitm_sequencer.sv - directed self-checking bench for spi_mitm_sequencer
module tb_spi_mitm_sequencer;

  localparam int H = 10;

  logic       sys_clk = 1'b0;
  logic       rst;
  logic       ss_in, sclk_in, mosi_in;
  logic [7:0] cfg_trigger, cfg_replace;
  logic [3:0] cfg_count;
  logic       cfg_arm;
  logic       armed, frame_active, miso_sel, miso_repl_bit;
  logic [7:0] mosi_byte;
  logic       byte_done, hit;

  int total = 0;
  int bad   = 0;

  int         bd_cnt  = 0;
  int         hit_cnt = 0;
  int         sel_cnt = 0;
  logic [7:0] seen [0:31];
  logic [7:0] hit_byte = 8'h00;

  logic [7:0] sel_log [0:3];
  logic [7:0] rb_log  [0:3];
  int         nbyte;

  spi_mitm_sequencer #(.DATA_SIZE(8), .CNT_W(4), .SYNC_STAGES(2)) dut (
    .sys_clk      (sys_clk),
    .rst          (rst),
    .ss_in        (ss_in),
    .sclk_in      (sclk_in),
    .mosi_in      (mosi_in),
    .cfg_trigger  (cfg_trigger),
    .cfg_replace  (cfg_replace),
    .cfg_count    (cfg_count),
    .cfg_arm      (cfg_arm),
    .armed        (armed),
    .frame_active (frame_active),
    .miso_sel     (miso_sel),
    .miso_repl_bit(miso_repl_bit),
    .mosi_byte    (mosi_byte),
    .byte_done    (byte_done),
    .hit          (hit)
  );

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) begin
    if (byte_done) begin
      seen[bd_cnt % 32] <= mosi_byte;
      bd_cnt <= bd_cnt + 1;
    end
    if (hit) begin
      hit_cnt  <= hit_cnt + 1;
      hit_byte <= mosi_byte;
    end
    if (miso_sel) sel_cnt <= sel_cnt + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic arm();
    cfg_arm = 1'b1;
    tick(1);
    cfg_arm = 1'b0;
  endtask

  task automatic frame_start();
    nbyte = 0;
    for (int k = 0; k < 4; k++) begin
      sel_log[k] = 8'h00;
      rb_log[k]  = 8'h00;
    end
    ss_in = 1'b1;
    tick(H);
  endtask

  task automatic frame_end();
    tick(H);
    ss_in = 1'b0;
    tick(2 * H);
  endtask

  // Mode-0 master: data changes after the fall, sampled on the rise; MISO controls logged just before each rise
  task automatic send_bits(input logic [7:0] b, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      mosi_in = b[7-i];
      tick(H);
      sel_log[nbyte][7-i] = miso_sel;
      rb_log[nbyte][7-i]  = miso_repl_bit;
      sclk_in = 1'b1;
      tick(H);
      sclk_in = 1'b0;
    end
    nbyte++;
  endtask

  int bd0, hit0, sel0;
  logic [7:0] mux;

  initial begin
    rst = 1'b1; ss_in = 1'b0; sclk_in = 1'b0; mosi_in = 1'b0;
    cfg_trigger = 8'h00; cfg_replace = 8'h00; cfg_count = 4'd0; cfg_arm = 1'b0;
    tick(3);
    check("rst_outputs", {armed, frame_active, miso_sel, miso_repl_bit, byte_done, hit}, 6'b0);
    check("rst_mosi_byte", mosi_byte, 8'h00);
    rst = 1'b0;
    tick(5);
    check("post_rst_frame_active", frame_active, 1'b0);

    // 1: armed trigger E7, replace one byte with A5; slave sends 3A,29
    cfg_trigger = 8'hE7; cfg_replace = 8'hA5; cfg_count = 4'd1;
    arm();
    check("t1_armed", armed, 1'b1);
    bd0 = bd_cnt; hit0 = hit_cnt;
    frame_start();
    check("t1_frame_active", frame_active, 1'b1);
    send_bits(8'hE7, 8);
    send_bits(8'h00, 8);
    frame_end();
    check("t1_byte_done_cnt", bd_cnt - bd0, 2);
    check("t1_byte0", seen[bd0 % 32], 8'hE7);
    check("t1_byte1", seen[(bd0 + 1) % 32], 8'h00);
    check("t1_hit_cnt", hit_cnt - hit0, 1);
    check("t1_hit_byte", hit_byte, 8'hE7);
    check("t1_armed_after", armed, 1'b0);
    check("t1_sel_b0", sel_log[0], 8'h00);
    check("t1_sel_b1", sel_log[1], 8'hFF);
    check("t1_repl_bits", rb_log[1], 8'hA5);
    mux = (sel_log[0] & rb_log[0]) | (~sel_log[0] & 8'h3A);
    check("t1_miso_b0", mux, 8'h3A);
    mux = (sel_log[1] & rb_log[1]) | (~sel_log[1] & 8'h29);
    check("t1_miso_b1", mux, 8'hA5);
    check("t1_idle_frame_active", frame_active, 1'b0);
    check("t1_idle_sel", miso_sel, 1'b0);

    // 2: unarmed, matching byte gives no hit and no substitution
    bd0 = bd_cnt; hit0 = hit_cnt; sel0 = sel_cnt;
    frame_start();
    send_bits(8'hE7, 8);
    frame_end();
    check("t2_byte_done_cnt", bd_cnt - bd0, 1);
    check("t2_byte", seen[bd0 % 32], 8'hE7);
    check("t2_hit_cnt", hit_cnt - hit0, 0);
    check("t2_sel_cycles", sel_cnt - sel0, 0);

    // 3: trigger F1; mismatch frame keeps armed, next frame hits
    cfg_trigger = 8'hF1;
    arm();
    hit0 = hit_cnt; sel0 = sel_cnt;
    frame_start();
    send_bits(8'hE7, 8);
    frame_end();
    check("t3_f1_hit_cnt", hit_cnt - hit0, 0);
    check("t3_f1_armed", armed, 1'b1);
    check("t3_f1_sel_cycles", sel_cnt - sel0, 0);
    bd0 = bd_cnt;
    frame_start();
    send_bits(8'hF1, 8);
    send_bits(8'h00, 8);
    frame_end();
    check("t3_f2_hit_cnt", hit_cnt - hit0, 1);
    check("t3_f2_hit_byte", hit_byte, 8'hF1);
    check("t3_f2_byte1", seen[(bd0 + 1) % 32], 8'h00);
    check("t3_f2_sel_b0", sel_log[0], 8'h00);
    check("t3_f2_sel_b1", sel_log[1], 8'hFF);
    check("t3_f2_repl_bits", rb_log[1], 8'hA5);
    check("t3_f2_armed", armed, 1'b0);

    // 4: count 2, frame ends after one replaced byte; replacement must not leak into the next frame
    cfg_trigger = 8'hE7; cfg_count = 4'd2;
    arm();
    frame_start();
    send_bits(8'hE7, 8);
    send_bits(8'h11, 8);
    check("t4_sel_b1", sel_log[1], 8'hFF);
    check("t4_repl_bits", rb_log[1], 8'hA5);
    tick(H);
    check("t4_sel_before_ss_fall", miso_sel, 1'b1);
    ss_in = 1'b0;
    tick(4);
    check("t4_sel_after_ss_fall", miso_sel, 1'b0);
    check("t4_repl_bit_after_ss_fall", miso_repl_bit, 1'b0);
    check("t4_frame_active_after_ss_fall", frame_active, 1'b0);
    tick(2 * H);
    sel0 = sel_cnt;
    frame_start();
    send_bits(8'h00, 8);
    send_bits(8'h00, 8);
    frame_end();
    check("t4_next_sel_cycles", sel_cnt - sel0, 0);
    check("t4_next_armed", armed, 1'b0);

    // 5: partial byte is dropped; next frame decodes cleanly
    bd0 = bd_cnt;
    frame_start();
    send_bits(8'hFF, 5);
    frame_end();
    check("t5_partial_byte_done", bd_cnt - bd0, 0);
    frame_start();
    send_bits(8'h3A, 8);
    frame_end();
    check("t5_next_byte_done", bd_cnt - bd0, 1);
    check("t5_next_byte", seen[bd0 % 32], 8'h3A);

    // 6: reset mid-frame with ss held high; no frame until ss is seen low then high
    arm();
    frame_start();
    send_bits(8'hC3, 3);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    check("t6_outputs_after_rst", {armed, frame_active, miso_sel, miso_repl_bit, byte_done, hit}, 6'b0);
    check("t6_mosi_byte_after_rst", mosi_byte, 8'h00);
    bd0 = bd_cnt;
    tick(H);
    send_bits(8'h81, 8);
    tick(H);
    check("t6_ss_high_frame_active", frame_active, 1'b0);
    check("t6_ss_high_byte_done", bd_cnt - bd0, 0);
    check("t6_ss_high_mosi_byte", mosi_byte, 8'h00);
    ss_in = 1'b0;
    tick(2 * H);
    frame_start();
    check("t6_frame_active", frame_active, 1'b1);
    send_bits(8'h5C, 8);
    frame_end();
    check("t6_byte_done_cnt", bd_cnt - bd0, 1);
    check("t6_byte", seen[bd0 % 32], 8'h5C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_mitm_sequencer.md
Name: spi_mitm_sequencer

Overview:
Per-frame controller for the SPI man-in-the-middle datapath. It observes the master-side SS/SCLK/MOSI inputs, assembles MOSI bytes and compares each against a configured trigger byte. On a match while armed, it drives the MISO output mux to substitute a configured byte for the next N bytes of the same frame. It sits beside the MITM pass-through path and owns the MISO select and replacement-bit signals.

Parameters:
DATA_SIZE, 8, bits per SPI byte; MSB first.
CNT_W, 4, width of the replacement byte counter cfg_count.
SYNC_STAGES, 2, synchronizer flops on ss_in, sclk_in and mosi_in; minimum 2.

Ports:
sys_clk  in  1  system clock; all logic on its rising edge.
rst  in  1  asynchronous, active-high reset.
ss_in  in  1  SPI frame select, active-high (frame = ss_in high), asynchronous to sys_clk.
sclk_in  in  1  SPI clock; data sampled on rising edge, changed on falling edge; asynchronous.
mosi_in  in  1  master data; asynchronous.
cfg_trigger  in  DATA_SIZE  MOSI byte that fires substitution.
cfg_replace  in  DATA_SIZE  byte driven on MISO in place of slave data.
cfg_count  in  CNT_W  number of bytes to replace after a hit; 0 = hit only, no replacement.
cfg_arm  in  1  one-cycle pulse; sets armed.
armed  out  1  substitution armed (one-shot).
frame_active  out  1  frame in progress.
miso_sel  out  1  1 = datapath drives miso_repl_bit on MISO out, 0 = pass-through.
miso_repl_bit  out  1  current replacement bit.
mosi_byte  out  DATA_SIZE  last complete MOSI byte; held until the next byte completes.
byte_done  out  1  one-cycle pulse when a full byte has been captured.
hit  out  1  one-cycle pulse when a byte matches cfg_trigger while armed.

Behaviour:
- Reset (async assert, sync release): all outputs 0. State IDLE. bit_cnt 0. Shift registers 0. The previous-SS register resets to 1, so a frame starts only after ss is seen low and then high. This prevents a false start when rst is released mid-frame.
- Input path: SYNC_STAGES flops, then a 1-flop edge detector giving ss_rise, ss_fall, sclk_rise and sclk_fall pulses. The latency from an input edge to its pulse is SYNC_STAGES+1 sys_clk cycles.
- Requirement: each SCLK half-period is at least 2*(SYNC_STAGES+2) sys_clk cycles.
- States: IDLE, WAIT_TRIG, REPLACE, PASS.
- IDLE:
  - On ss_rise, frame_active goes to 1 and bit_cnt clears.
  - If armed, go to WAIT_TRIG; otherwise go to PASS.
- Capture, in any non-IDLE state: on sclk_rise, shift the synced mosi in at the LSB and increment bit_cnt.
  - When bit_cnt reaches DATA_SIZE, load mosi_byte, pulse byte_done in the same cycle, and clear bit_cnt to 0.
- WAIT_TRIG: on byte completion with byte == cfg_trigger, pulse hit (same cycle as byte_done) and clear armed.
  - If cfg_count != 0, load rem = cfg_count and go to REPLACE.
  - Otherwise go to PASS.
  - On a mismatch, stay in WAIT_TRIG; armed stays 1.
- REPLACE:
  - On the first sclk_fall with bit_cnt == 0, load the output shift register with cfg_replace, set miso_sel = 1 and drive miso_repl_bit = MSB.
  - Each later sclk_fall shifts the next bit out, MSB first.
  - On byte completion, decrement rem. When rem reaches 0, go to PASS, with miso_sel dropping at the next sclk_fall so the last bit stays valid across its rising edge.
- PASS: capture only; miso_sel stays 0.
- ss_fall in any state:
  - Go to IDLE. frame_active, miso_sel and miso_repl_bit go to 0 one cycle later.
  - bit_cnt clears. A partial byte is discarded, with no byte_done.
  - Unfinished replacement is cancelled and is not carried to the next frame.
  - armed is unchanged.
- cfg_arm: sets armed in any state. If asserted mid-frame, it takes effect at the next ss_rise; the current frame's state is unaffected.
- cfg_arm coinciding with hit: set wins, so armed stays 1.
- cfg_* inputs are sampled at use:
  - cfg_trigger at compare.
  - cfg_count at the hit.
  - cfg_replace at each byte load.
- Simultaneous ss_fall and sclk_rise pulses: ss_fall wins and the bit is dropped.

Test Plan:
1. Arm, with cfg_trigger=8'hE7, cfg_replace=8'hA5, cfg_count=1. Send a frame of MOSI E7,00 with slave MISO 3A,29.
   - byte_done twice; mosi_byte E7 then 00.
   - hit once, on the first byte; armed goes to 0.
   - miso_sel=1 only during byte 2, with miso_repl_bit sequence 1,0,1,0,0,1,0,1.
2. Leave unarmed and send MOSI E7 → byte_done, mosi_byte=E7, hit never pulses, miso_sel stays 0 for the whole frame.
3. Arm with cfg_trigger=8'hF1 and send MOSI E7, then a second frame with F1,00.
   - No hit in frame 1; armed stays 1.
   - Frame 2: hit on F1, and byte 00's MISO is replaced with cfg_replace.
4. Arm with cfg_count=2 and send MOSI E7,11, then SS falls.
   - Byte 2 is replaced.
   - miso_sel=0 within SYNC_STAGES+2 cycles of the SS fall.
   - The next frame (unarmed) shows no replacement.
5. Send 5 bits of 8'hFF, then SS falls; the next frame sends 8'h3A → no byte_done for the partial byte, and the next mosi_byte=3A.
6. Assert rst mid-frame while ss_in is held high, then release.
   - All outputs are 0 and stay 0 while ss_in stays high.
   - After ss_in goes low then high, frame_active=1 and bytes decode correctly.
